updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised successor to the basic loadable up-counter.
//   Adds up/down counting, a programmable modulus (terminal value), and selectable wrap or saturate mode.
//   Outputs a registered terminal-count pulse and a sticky overflow flag.
//   Used for timers, BCD/decade digits and event tallies in the lab datapaths.
// PARAMETERS
//   WIDTH     5   counter width in bits
//   MAX_VAL   31  terminal count; legal range 1 .. 2**WIDTH-1; count range is 0..MAX_VAL
//   SATURATE  0   0 = wrap at the bounds; 1 = hold at the bounds
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active-high
//   clr      in   1      synchronous clear of the count and ovf
//   load     in   1      synchronous load of cnt_in
//   enab     in   1      count enable
//   up_dn    in   1      direction: 1 = increment, 0 = decrement
//   cnt_in   in   WIDTH  load value
//   ovf_clr  in   1      synchronous clear of ovf only
//   cnt_out  out  WIDTH  registered count
//   tc       out  1      registered 1-cycle pulse on a bound event
//   ovf      out  1      sticky flag: a bound event has occurred
// BEHAVIOUR
//   Reset (async, rst=1): cnt_out=0, tc=0, ovf=0, held while rst=1.
//     First update occurs on the first clk edge after rst deasserts.
//   All outputs are registered. Inputs sampled at edge N are visible in cnt_out/tc/ovf just after edge N.
//     No combinational path from inputs to outputs.
//   Command priority at each edge: rst > clr > load > enab > hold.
//     clr:        cnt_out<=0, ovf<=0, tc<=0.
//     load:       cnt_out<=cnt_in if cnt_in<=MAX_VAL, else cnt_out<=MAX_VAL (clamp).
//                 tc<=0; ovf unchanged except by ovf_clr.
//     enab, up:   cnt_out<MAX_VAL -> cnt_out+1, tc<=0.
//                 cnt_out>=MAX_VAL -> bound event: SATURATE=0 gives 0; SATURATE=1 gives MAX_VAL.
//     enab, down: cnt_out>0 -> cnt_out-1, tc<=0.
//                 cnt_out==0 -> bound event: SATURATE=0 gives MAX_VAL; SATURATE=1 gives 0.
//     hold:       cnt_out unchanged, tc<=0.
//   Bound event: tc<=1 for exactly that cycle; ovf<=1.
//     With SATURATE=1, each enabled cycle spent at the bound is a new event (tc stays high).
//   ovf: set by a bound event; cleared by ovf_clr or clr.
//     A bound event and ovf_clr in the same cycle: set wins, ovf=1.
//   up_dn may change on any cycle; it takes effect on that cycle's edge. No turnaround penalty.
//   Arithmetic is WIDTH bits, unsigned. Next state is computed from cnt_out only.
//     No feedback from the next-state logic to itself.
//     Values above MAX_VAL are unreachable except via out-of-range parameters (illegal).
//   rst asserted mid-count clears all outputs immediately, independent of clk.
// TESTING (WIDTH=4, MAX_VAL=9 unless noted)
//   T1 reset: rst pulse between edges -> cnt_out=0, tc=0, ovf=0 immediately; enab=1, up=1 for 3 clks -> 1,2,3.
//   T2 decade wrap: load 8, then enab up 3 clks -> 9, 0 (tc=1, ovf=1), 1 (tc=0); ovf stays 1.
//   T3 down wrap + clamp: load 15 -> cnt_out=9; load 0, enab down 1 clk -> 9, tc=1.
//   T4 saturate (SATURATE=1): from 8, enab up 3 clks -> 9, 9 (tc=1), 9 (tc=1); down at 0 holds 0 with tc=1.
//   T5 priority: clr=load=enab=1 -> cnt_out=0, ovf=0; load=enab=1, cnt_in=5 -> 5.
//      Bound event with ovf_clr=1 -> ovf=1.
//   T6 random: 2000 cycles of random inputs plus occasional async rst, checked against a reference model every edge.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - command and status bundle for the up/down modulus counter
interface updown_mod_counter_if #(
  parameter int WIDTH = 5
);
  logic             clr;
  logic             load;
  logic             enab;
  logic             up_dn;
  logic [WIDTH-1:0] cnt_in;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             ovf;

  // Driver side: issues commands, observes count and flags.
  modport master (
    output clr, load, enab, up_dn, cnt_in, ovf_clr,
    input  cnt_out, tc, ovf
  );

  // Counter side: consumes commands, produces count and flags.
  modport slave (
    input  clr, load, enab, up_dn, cnt_in, ovf_clr,
    output cnt_out, tc, ovf
  );
endinterface

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - loadable up/down counter with programmable terminal value, wrap or saturate
module updown_mod_counter #(
  parameter int WIDTH    = 5,
  parameter int MAX_VAL  = 31,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_mod_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;

  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             bound_evt;

  // Next state from the registered count only: clr > load > enab > hold.
  always_comb begin
    cnt_nxt   = cnt_q;
    bound_evt = 1'b0;
    if (bus.clr) begin
      cnt_nxt = ZERO_W;
    end else if (bus.load) begin
      cnt_nxt = (bus.cnt_in > MAX_W) ? MAX_W : bus.cnt_in;
    end else if (bus.enab) begin
      if (bus.up_dn) begin
        if (cnt_q < MAX_W) begin
          cnt_nxt = cnt_q + ONE_W;
        end else begin
          bound_evt = 1'b1;
          cnt_nxt   = SATURATE ? MAX_W : ZERO_W;
        end
      end else begin
        if (cnt_q != ZERO_W) begin
          cnt_nxt = cnt_q - ONE_W;
        end else begin
          bound_evt = 1'b1;
          cnt_nxt   = SATURATE ? ZERO_W : MAX_W;
        end
      end
    end

    tc_nxt = bound_evt;
    // A bound event beats ovf_clr in the same cycle; clr always wins.
    if (bus.clr) begin
      ovf_nxt = 1'b0;
    end else if (bound_evt) begin
      ovf_nxt = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf_q;
    end
  end

  // State registers; rst clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tc_q  <= tc_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
endmodule
